// File: rtl/wb_cache_arbiter.sv
// wb_cache_arbiter: round-robin Wishbone arbiter (icache m0, dcache m1) onto one SDRAM slave with a stall watchdog.
module wb_cache_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] m0_adr_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [2:0]    m0_cti_i,
  input  logic [1:0]    m0_bte_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic [DW-1:0] m1_adr_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [2:0]    m1_cti_i,
  input  logic [1:0]    m1_bte_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [DW-1:0] s_adr_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [2:0]    s_cti_o,
  output logic [1:0]    s_bte_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  output logic [1:0]    grant,
  output logic          timeout_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  localparam logic [1:0] S_IDLE = 2'd0, S_GNT0 = 2'd1, S_GNT1 = 2'd2, S_ABORT = 2'd3;
  logic [1:0] st_q, st_d, blk_q, blk_d;
  logic last_q, last_d;
  logic [CW-1:0] wdt_q, wdt_d;
  logic ing, sel1, cyc_g, stb_g, r0, r1, hit, g0, g1, ab;
  assign ing = st_q == S_GNT0 || st_q == S_GNT1;
  assign sel1 = st_q == S_GNT1;
  assign cyc_g = sel1 ? m1_cyc_i : m0_cyc_i;
  assign stb_g = sel1 ? m1_stb_i : m0_stb_i;
  // an aborted master stays locked out until it lets go of cyc once
  assign r0 = m0_cyc_i & ~blk_q[0];
  assign r1 = m1_cyc_i & ~blk_q[1];
  assign hit = ing & cyc_g & (wdt_d == TMAX);
  always_comb begin
    wdt_d = (!ing || s_ack_i || s_err_i) ? '0 : (stb_g && wdt_q != TMAX) ? wdt_q + 1'b1 : wdt_q;
    st_d = st_q == S_IDLE ? ((r0 & (~r1 | last_q)) ? S_GNT0 : r1 ? S_GNT1 : S_IDLE) :
           st_q == S_ABORT ? S_IDLE : !cyc_g ? S_IDLE : hit ? S_ABORT : st_q;
    last_d = (ing & (~cyc_g | hit)) ? sel1 : last_q;
    blk_d = (blk_q & {m1_cyc_i, m0_cyc_i}) | (hit ? {sel1, ~sel1} : 2'b00);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= S_IDLE;
      last_q <= 1'b1;
      blk_q <= 2'b00;
      wdt_q <= '0;
    end else begin
      st_q <= st_d;
      last_q <= last_d;
      blk_q <= blk_d;
      wdt_q <= wdt_d;
    end
  end
  assign g0 = ~rst & (st_q == S_GNT0);
  assign g1 = ~rst & (st_q == S_GNT1);
  assign ab = ~rst & (st_q == S_ABORT);
  assign s_adr_o = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
  assign s_cyc_o = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
  assign s_stb_o = (g0 & m0_stb_i) | (g1 & m1_stb_i);
  assign s_we_o = (g0 & m0_we_i) | (g1 & m1_we_i);
  assign s_sel_o = g0 ? m0_sel_i : g1 ? m1_sel_i : 4'd0;
  assign s_cti_o = g0 ? m0_cti_i : g1 ? m1_cti_i : 3'd0;
  assign s_bte_o = g0 ? m0_bte_i : g1 ? m1_bte_i : 2'd0;
  assign s_dat_o = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = g0 & s_ack_i;
  assign m1_ack_o = g1 & s_ack_i;
  assign m0_err_o = (g0 & s_err_i) | (ab & ~last_q);
  assign m1_err_o = (g1 & s_err_i) | (ab & last_q);
  assign grant = {g1 | (ab & last_q), g0 | (ab & ~last_q)};
  assign timeout_o = ab;
endmodule

// File: tb/tb_wb_cache_arbiter.sv
// tb_wb_cache_arbiter: directed scenarios plus randomized traffic against an ownership-level reference model.
module tb_wb_cache_arbiter;
  localparam int TO = 255;
  logic clk, rst;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
  logic m0_cyc_i, m0_stb_i, m0_we_i, m0_ack_o, m0_err_o;
  logic m1_cyc_i, m1_stb_i, m1_we_i, m1_ack_o, m1_err_o;
  logic [3:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic [2:0] m0_cti_i, m1_cti_i, s_cti_o;
  logic [1:0] m0_bte_i, m1_bte_i, s_bte_o, grant;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, timeout_o;
  int checks = 0, failures = 0;

  wb_cache_arbiter #(.TIMEOUT(TO), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant(grant), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: owner 0=none, 1=m0, 2=m1; ab_own is the master being aborted this cycle
  int own = 0, ab_own = 0, last = 1, cnt = 0;
  bit [1:0] blk = 2'b00;
  always @(posedge clk) begin
    if (rst) begin
      own = 0; ab_own = 0; last = 1; cnt = 0; blk = 2'b00;
    end else begin
      blk = blk & {m1_cyc_i, m0_cyc_i};
      if (ab_own != 0) ab_own = 0;
      else if (own == 0) begin
        cnt = 0;
        if (m0_cyc_i && !blk[0] && m1_cyc_i && !blk[1]) own = (last == 1) ? 1 : 2;
        else if (m0_cyc_i && !blk[0]) own = 1;
        else if (m1_cyc_i && !blk[1]) own = 2;
      end else if (!(own == 1 ? m0_cyc_i : m1_cyc_i)) begin
        last = own - 1; own = 0;
      end else begin
        if (s_ack_i || s_err_i) cnt = 0;
        else if ((own == 1 ? m0_stb_i : m1_stb_i) && cnt < TO) cnt++;
        if (cnt == TO) begin
          ab_own = own; last = own - 1; blk[own-1] = 1'b1; own = 0;
        end
      end
    end
  end
  logic [1:0] e_grant, e_ack, e_err;
  logic e_to, e_scyc;
  always_comb begin
    e_grant = rst ? 2'b00 : {own == 2 || ab_own == 2, own == 1 || ab_own == 1};
    e_ack = rst ? 2'b00 : {own == 2 && s_ack_i, own == 1 && s_ack_i};
    e_err = rst ? 2'b00 : {(own == 2 && s_err_i) || ab_own == 2, (own == 1 && s_err_i) || ab_own == 1};
    e_to = !rst && ab_own != 0;
    e_scyc = !rst && ((own == 1 && m0_cyc_i) || (own == 2 && m1_cyc_i));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; s_ack_i = 1'b1; s_err_i = 1'b1; s_dat_i = 32'h1234_5678;
    tick();
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++; if ({s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, timeout_o} !== 8'h00) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000000", {s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, timeout_o}); end
    checks++; if (s_adr_o !== 32'h0 || s_dat_o !== 32'h0) begin failures++; $display("FAIL reset_bus adr=%h dat=%h exp=0", s_adr_o, s_dat_o); end
    checks++; if (m0_dat_o !== 32'h1234_5678 || m1_dat_o !== 32'h1234_5678) begin
      failures++; $display("FAIL reset_rdata m0=%h m1=%h exp=12345678", m0_dat_o, m1_dat_o); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({m0_ack_o, m1_ack_o} !== 2'b00) begin failures++; $display("FAIL idle_ack_drop got=%b exp=00", {m0_ack_o, m1_ack_o}); end
    s_ack_i = 1'b0; s_err_i = 1'b0;
    tick();
  endtask

  task automatic test_tie_fill;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_cti_i = 3'b010; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 2'b00 || s_cyc_o !== 1'b0) begin failures++; $display("FAIL tie_dead_cycle grant=%b cyc=%b exp=00/0", grant, s_cyc_o); end
    tick();
    for (int i = 0; i < 17; i++) begin
      m0_stb_i = (i != 8);
      s_ack_i = m0_stb_i;
      m0_cti_i = (i == 7 || i == 16) ? 3'b111 : 3'b010;
      m0_adr_i = 32'h2000 + 32'((i > 8 ? i - 1 : i) * 4);
      s_dat_i = $urandom;
      @(negedge clk);
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL fill_grant beat=%0d got=%b exp=01", i, grant); end
      checks++; if (m0_ack_o !== s_ack_i || m1_ack_o !== 1'b0 || s_adr_o !== m0_adr_i || s_cti_o !== m0_cti_i || m0_dat_o !== s_dat_i) begin
        failures++; $display("FAIL fill_route beat=%0d ack=%b%b adr=%h cti=%b", i, m1_ack_o, m0_ack_o, s_adr_o, s_cti_o); end
      tick();
    end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL fill_drop_hold got=%b exp=01", grant); end
    tick();
    @(negedge clk);
    checks++; if (grant !== 2'b00 || s_cyc_o !== 1'b0) begin failures++; $display("FAIL handover_idle grant=%b cyc=%b exp=00/0", grant, s_cyc_o); end
    tick();
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL handover_m1 got=%b exp=10", grant); end
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_write;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 32'h100; m1_dat_i = 32'hDEAD_BEEF; m1_sel_i = 4'hF;
    tick();
    @(negedge clk);
    checks++; if (grant !== 2'b10 || s_adr_o !== 32'h100 || s_dat_o !== 32'hDEADBEEF || s_we_o !== 1'b1 || s_sel_o !== 4'hF) begin
      failures++; $display("FAIL write_bus grant=%b adr=%h dat=%h we=%b sel=%h", grant, s_adr_o, s_dat_o, s_we_o, s_sel_o); end
    checks++; if ({m0_ack_o, m1_ack_o} !== 2'b00) begin failures++; $display("FAIL write_noack got=%b exp=00", {m0_ack_o, m1_ack_o}); end
    s_ack_i = 1'b1;
    #1;
    checks++; if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin failures++; $display("FAIL write_ack m1=%b m0=%b exp=1/0", m1_ack_o, m0_ack_o); end
    s_err_i = 1'b1;
    #1;
    checks++; if ({m1_ack_o, m1_err_o, m0_ack_o, m0_err_o} !== 4'b1100) begin
      failures++; $display("FAIL ack_err_both got=%b exp=1100", {m1_ack_o, m1_err_o, m0_ack_o, m0_err_o}); end
    tick();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; s_ack_i = 1'b0; s_err_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout;
    int n;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_cti_i = 3'b000;
    tick();
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (timeout_o) break;
      n++;
      tick();
    end
    checks++; if (n !== TO) begin failures++; $display("FAIL timeout_stall_cycles got=%0d exp=%0d", n, TO); end
    checks++; if ({timeout_o, m0_err_o, m1_err_o, s_cyc_o, s_stb_o} !== 5'b11000) begin
      failures++; $display("FAIL abort_outputs got=%b exp=11000", {timeout_o, m0_err_o, m1_err_o, s_cyc_o, s_stb_o}); end
    tick();
    @(negedge clk);
    checks++; if (grant !== 2'b00 || timeout_o !== 1'b0 || m0_err_o !== 1'b0) begin
      failures++; $display("FAIL after_abort grant=%b to=%b err=%b exp=00/0/0", grant, timeout_o, m0_err_o); end
    tick(); tick(); tick();
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL abort_lockout got=%b exp=00", grant); end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL relock_grant got=%b exp=01", grant); end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_burst;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_cti_i = 3'b010; s_ack_i = 1'b1;
    tick();
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      checks++; if (grant !== 2'b10 || m1_ack_o !== 1'b1) begin failures++; $display("FAIL rb_beat%0d grant=%b ack=%b exp=10/1", b, grant, m1_ack_o); end
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({grant, s_cyc_o, s_stb_o, m1_ack_o, m1_err_o, m0_err_o, timeout_o} !== 8'h00) begin
      failures++; $display("FAIL rb_during got=%b exp=00000000", {grant, s_cyc_o, s_stb_o, m1_ack_o, m1_err_o, m0_err_o, timeout_o}); end
    tick();
    rst = 1'b0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    @(negedge clk);
    checks++; if ({grant, s_cyc_o, s_stb_o, m1_ack_o, m1_err_o, m0_err_o, timeout_o} !== 8'h00) begin
      failures++; $display("FAIL rb_after got=%b exp=00000000", {grant, s_cyc_o, s_stb_o, m1_ack_o, m1_err_o, m0_err_o, timeout_o}); end
    tick();
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rb_fresh_tie got=%b exp=01", grant); end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      m0_cyc_i = m0_cyc_i ? ($urandom_range(5) != 0) : ($urandom_range(3) == 0);
      m1_cyc_i = m1_cyc_i ? ($urandom_range(5) != 0) : ($urandom_range(3) == 0);
      m0_stb_i = m0_cyc_i & $urandom_range(1);
      m1_stb_i = m1_cyc_i & $urandom_range(1);
      m0_we_i = $urandom_range(1); m1_we_i = $urandom_range(1);
      m0_adr_i = $urandom; m1_adr_i = $urandom; m0_dat_i = $urandom; m1_dat_i = $urandom; s_dat_i = $urandom;
      s_ack_i = $urandom_range(1); s_err_i = ($urandom_range(15) == 0);
      @(negedge clk);
      checks++; if ({grant, m1_ack_o, m0_ack_o, m1_err_o, m0_err_o, timeout_o, s_cyc_o} !== {e_grant, e_ack, e_err, e_to, e_scyc}) begin
        failures++; $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", i, {grant, m1_ack_o, m0_ack_o, m1_err_o, m0_err_o, timeout_o, s_cyc_o}, {e_grant, e_ack, e_err, e_to, e_scyc}); end
      if (e_grant != 2'b00 && !e_to) begin
        checks++; if (s_adr_o !== (e_grant[0] ? m0_adr_i : m1_adr_i) || s_dat_o !== (e_grant[0] ? m0_dat_i : m1_dat_i)) begin
          failures++; $display("FAIL rand_route cyc=%0d adr=%h dat=%h", i, s_adr_o, s_dat_o); end
      end
      tick();
    end
    m0_cyc_i = 1'b0; m1_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0; s_err_i = 1'b0;
    tick(); tick();
  endtask

  initial begin
    rst = 1'b1;
    {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i, s_ack_i, s_err_i} = '0;
    m0_adr_i = '0; m0_dat_i = '0; m1_adr_i = '0; m1_dat_i = '0; s_dat_i = '0;
    m0_sel_i = 4'hF; m1_sel_i = 4'hF; m0_cti_i = '0; m1_cti_i = '0; m0_bte_i = '0; m1_bte_i = '0;
    test_reset();
    test_tie_fill();
    test_write();
    test_timeout();
    test_reset_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
